// File: rtl/fast_gpio_bank.sv
// N channels of WIDTH-bit GPIO behind one register bus: output data/enable, synchronised
// inputs, atomic set/clear/toggle and sticky rising-edge interrupts. Never drives Z.
module fast_gpio_bank #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned AW         = $clog2(N) + 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sel,
    input  logic               wen,
    input  logic               ren,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   datain,
    output logic [WIDTH-1:0]   dataout,
    output logic               rvalid,
    input  logic [N*WIDTH-1:0] gpio_i,
    output logic [N*WIDTH-1:0] gpio_o,
    output logic [N*WIDTH-1:0] gpio_oe,
    output logic               irq
);

    typedef enum logic [2:0] {
        RegDataOut = 3'd0,
        RegOe      = 3'd1,
        RegDataIn  = 3'd2,
        RegSet     = 3'd3,
        RegClr     = 3'd4,
        RegTog     = 3'd5,
        RegIrqEn   = 3'd6,
        RegIrqStat = 3'd7
    } reg_e;

    logic [WIDTH-1:0]   out_q  [N];
    logic [WIDTH-1:0]   out_d  [N];
    logic [WIDTH-1:0]   oe_q   [N];
    logic [WIDTH-1:0]   oe_d   [N];
    logic [WIDTH-1:0]   ien_q  [N];
    logic [WIDTH-1:0]   ien_d  [N];
    logic [WIDTH-1:0]   stat_q [N];
    logic [WIDTH-1:0]   stat_d [N];
    logic [N*WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [N*WIDTH-1:0] prev_q;
    logic [N*WIDTH-1:0] sync;
    logic [N*WIDTH-1:0] rise;
    logic [AW-1:0]      chan;
    reg_e               reg_sel;
    logic               wr_en;
    logic               rd_en;
    logic [WIDTH-1:0]   rdata;

    // Channel indices >= N match no loop iteration, so such writes drop and reads return 0.
    assign chan    = addr >> 3;
    assign reg_sel = reg_e'(addr[2:0]);
    assign wr_en   = sel & wen;
    assign rd_en   = sel & ren;
    assign sync    = sync_q[SYNC_STAGES-1];
    assign rise    = sync & ~prev_q;

    always_comb begin
        for (int n = 0; n < N; n++) begin
            out_d[n]  = out_q[n];
            oe_d[n]   = oe_q[n];
            ien_d[n]  = ien_q[n];
            stat_d[n] = stat_q[n] | (rise[n*WIDTH +: WIDTH] & ien_q[n]);
            if (wr_en && (chan == AW'(n))) begin
                unique case (reg_sel)
                    RegDataOut: out_d[n] = datain;
                    RegOe:      oe_d[n]  = datain;
                    RegSet:     out_d[n] = out_q[n] | datain;
                    RegClr:     out_d[n] = out_q[n] & ~datain;
                    RegTog:     out_d[n] = out_q[n] ^ datain;
                    RegIrqEn:   ien_d[n] = datain;
                    // A new rising edge in the same cycle beats the clear.
                    RegIrqStat: stat_d[n] = (stat_q[n] & ~datain)
                                          | (rise[n*WIDTH +: WIDTH] & ien_q[n]);
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int n = 0; n < N; n++) begin
            if (chan == AW'(n)) begin
                unique case (reg_sel)
                    RegDataOut, RegSet, RegClr, RegTog: rdata = out_q[n];
                    RegOe:      rdata = oe_q[n];
                    RegDataIn:  rdata = sync[n*WIDTH +: WIDTH];
                    RegIrqEn:   rdata = ien_q[n];
                    RegIrqStat: rdata = stat_q[n];
                    default:    rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        irq     = 1'b0;
        gpio_o  = '0;
        gpio_oe = '0;
        for (int n = 0; n < N; n++) begin
            irq                       = irq | (|(stat_q[n] & ien_q[n]));
            gpio_o[n*WIDTH +: WIDTH]  = out_q[n];
            gpio_oe[n*WIDTH +: WIDTH] = oe_q[n];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < N; n++) begin
                out_q[n]  <= '0;
                oe_q[n]   <= '0;
                ien_q[n]  <= '0;
                stat_q[n] <= '0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q  <= '0;
            dataout <= '0;
            rvalid  <= 1'b0;
        end else begin
            for (int n = 0; n < N; n++) begin
                out_q[n]  <= out_d[n];
                oe_q[n]   <= oe_d[n];
                ien_q[n]  <= ien_d[n];
                stat_q[n] <= stat_d[n];
            end
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync;
            rvalid <= rd_en;
            // Read mux sees pre-write register values, so a combined write+read returns old data.
            if (rd_en) begin
                dataout <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_fast_gpio_bank.sv
// Bench for fast_gpio_bank: vector table, hand-written irq/reset sequences and a random
// phase, all checked every cycle against a register-level reference model.
module tb_fast_gpio_bank;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             sel;
    logic             wen;
    logic             ren;
    logic [AW-1:0]    addr;
    logic [31:0]      datain;
    logic [31:0]      dataout;
    logic             rvalid;
    logic [127:0]     gpio_i;
    logic [127:0]     gpio_o;
    logic [127:0]     gpio_oe;
    logic             irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fast_gpio_bank #(
        .WIDTH       (WIDTH),
        .N           (N),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sel     (sel),
        .wen     (wen),
        .ren     (ren),
        .addr    (addr),
        .datain  (datain),
        .dataout (dataout),
        .rvalid  (rvalid),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    // Reference model: register file plus a history of pad samples (index 0 = newest).
    logic [31:0]  m_out  [4];
    logic [31:0]  m_oe   [4];
    logic [31:0]  m_ien  [4];
    logic [31:0]  m_stat [4];
    logic [127:0] pad_hist [$];
    logic [31:0]  m_dout;
    logic         m_rv;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_o;
        logic [31:0] exp_oe;
        logic        exp_rv;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_out[n]  = '0;
            m_oe[n]   = '0;
            m_ien[n]  = '0;
            m_stat[n] = '0;
        end
        pad_hist.delete();
        for (int i = 0; i <= SYNC; i++) pad_hist.push_back('0);
        m_dout = '0;
        m_rv   = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int ch, input int r, input logic [127:0] s);
        case (r)
            1:       return m_oe[ch];
            2:       return s[ch*32 +: 32];
            6:       return m_ien[ch];
            7:       return m_stat[ch];
            default: return m_out[ch];
        endcase
    endfunction

    function automatic logic m_irq();
        logic v = 1'b0;
        for (int n = 0; n < 4; n++) v = v | (|(m_stat[n] & m_ien[n]));
        return v;
    endfunction

    // Applies one clock edge's worth of register semantics using the current bus/pad inputs.
    function automatic void model_edge();
        logic [127:0] s_v;
        logic [127:0] rise_v;
        int           ch;
        int           r;
        logic         w;
        s_v    = pad_hist[SYNC-1];
        rise_v = s_v & ~pad_hist[SYNC];
        ch     = int'(addr[4:3]);
        r      = int'(addr[2:0]);
        w      = sel && wen;
        m_rv   = sel && ren;
        if (m_rv) m_dout = m_read(ch, r, s_v);
        for (int n = 0; n < 4; n++) begin
            logic [31:0] clr = (w && n == ch && r == 7) ? datain : 32'h0;
            m_stat[n] = (m_stat[n] & ~clr) | (rise_v[n*32 +: 32] & m_ien[n]);
        end
        if (w) begin
            case (r)
                0: m_out[ch] = datain;
                1: m_oe[ch]  = datain;
                3: m_out[ch] = m_out[ch] | datain;
                4: m_out[ch] = m_out[ch] & ~datain;
                5: m_out[ch] = m_out[ch] ^ datain;
                6: m_ien[ch] = datain;
                default: ;
            endcase
        end
        pad_hist.push_front(gpio_i);
        void'(pad_hist.pop_back());
    endfunction

    task automatic check_all();
        chk("gpio_o", gpio_o, {m_out[3], m_out[2], m_out[1], m_out[0]});
        chk("gpio_oe", gpio_oe, {m_oe[3], m_oe[2], m_oe[1], m_oe[0]});
        chk("rvalid", rvalid, m_rv);
        chk("dataout", dataout, m_dout);
        chk("irq", irq, m_irq());
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic bus_idle();
        sel = 1'b0; wen = 1'b0; ren = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; wen = 1'b1; ren = 1'b0; addr = a; datain = d;
        step();
        bus_idle();
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
        sel = 1'b1; wen = 1'b0; ren = 1'b1; addr = a;
        step();
        chk({name, "_rvalid"}, rvalid, 1'b1);
        chk(name, dataout, exp);
        bus_idle();
    endtask

    initial begin
        logic [127:0] m;
        vecs[0]  = '{1'b1, 1'b0, 5'd16, 32'h0000_00F0, 32'h0000_00F0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 5'd19, 32'h0000_000F, 32'h0000_00FF, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd20, 32'h0000_0030, 32'h0000_00CF, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 5'd21, 32'h8000_0000, 32'h8000_00CF, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd19, 32'h0,         32'h8000_00CF, 32'h0, 1'b1, 32'h8000_00CF};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 5'd0,  32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 1'b1, 32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b1, 5'd2,  32'h0,         32'hAAAA_5555, 32'h0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 5'd1,  32'hFFFF_0000, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 5'd1,  32'h0,         32'hAAAA_5555, 32'hFFFF_0000, 1'b1,
                     32'hFFFF_0000};
        vecs[10] = '{1'b1, 1'b0, 5'd2,  32'hFFFF_FFFF, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 5'd2,  32'h0,         32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 32'h0};

        rstn = 1'b0; gpio_i = '0; addr = '0; datain = '0;
        bus_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rstn = 1'b1;

        // Back-to-back reads of every address after reset.
        for (int a = 0; a < 32; a++) begin
            sel = 1'b1; ren = 1'b1; addr = 5'(a);
            step();
            chk("reset_read_rvalid", rvalid, 1'b1);
            chk("reset_read_data", dataout, 32'h0);
        end
        bus_idle();
        step();
        chk("rvalid_drop", rvalid, 1'b0);

        for (int i = 0; i < 12; i++) begin
            sel = 1'b1; wen = vecs[i].wen; ren = vecs[i].ren;
            addr = vecs[i].addr; datain = vecs[i].din;
            step();
            chk($sformatf("vec%0d_o", i), gpio_o[int'(vecs[i].addr[4:3])*32 +: 32], vecs[i].exp_o);
            chk($sformatf("vec%0d_oe", i), gpio_oe[int'(vecs[i].addr[4:3])*32 +: 32],
                vecs[i].exp_oe);
            chk($sformatf("vec%0d_rv", i), rvalid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk($sformatf("vec%0d_dout", i), dataout, vecs[i].exp_dout);
        end
        bus_idle();

        // Pad-to-status latency and interrupt masking on channel 1.
        wr(5'd14, 32'h1);
        gpio_i[32] = 1'b1;
        step();
        step();
        chk("irq_before_edge3", irq, 1'b0);
        step();
        chk("irq_after_edge3", irq, 1'b1);
        rd(5'd15, "stat_set", 32'h1);
        wr(5'd15, 32'h1);
        chk("irq_after_w1c", irq, 1'b0);
        gpio_i[33] = 1'b1;
        repeat (4) step();
        chk("irq_masked_bit", irq, 1'b0);
        rd(5'd15, "stat_masked", 32'h0);

        // Fresh rise lands on the same edge as a W1C: status must survive.
        gpio_i[32] = 1'b0;
        repeat (3) step();
        gpio_i[32] = 1'b1;
        repeat (3) step();
        chk("irq_second_rise", irq, 1'b1);
        gpio_i[32] = 1'b0;
        repeat (3) step();
        gpio_i[32] = 1'b1;
        step();
        step();
        sel = 1'b1; wen = 1'b1; addr = 5'd15; datain = 32'h1;
        step();
        bus_idle();
        chk("irq_set_beats_clear", irq, 1'b1);
        step();
        chk("irq_hold", irq, 1'b1);
        rd(5'd15, "stat_after_collision", 32'h1);

        // Reset while a read is in flight and status is pending.
        sel = 1'b1; ren = 1'b1; addr = 5'd15;
        step();
        bus_idle();
        chk("inflight_rvalid", rvalid, 1'b1);
        rstn = 1'b0;
        gpio_i = '0;
        #1;
        model_reset();
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_gpio_o", gpio_o, 128'h0);
        check_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int a = 0; a < 32; a++) rd(5'(a), "post_reset_read", 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            sel    = ($urandom_range(0, 3) != 0);
            wen    = 1'($urandom_range(0, 1));
            ren    = 1'($urandom_range(0, 1));
            addr   = 5'($urandom);
            datain = (addr[2:0] == 3'd6) ? ($urandom & $urandom) : $urandom;
            if ($urandom_range(0, 2) == 0) begin
                m = {$urandom, $urandom, $urandom, $urandom}
                  & {$urandom, $urandom, $urandom, $urandom};
                gpio_i = gpio_i ^ m;
            end
            step();
        end
        bus_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
